bcd_clock: RTL and testbench

Free-running 24-hour time-of-day counter for the alarm-clock design, clocked from the 100 MHz board clock. A prescaler produces a 1 Hz enable. Hours, minutes and seconds are kept as six packed BCD digits on a 24-bit bus. The bus drives the display multiplexer and the alarm comparator. A synchronous load port sets the time.

---
 rtl/bcd_clock.sv | 94 +++++++++
 tb/tb_bcd_clock.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_clock.sv
// 24-hour time-of-day counter: a prescaler produces a once-per-second advance of
// six packed BCD digits (HH:MM:SS), with a validated synchronous load port.
module bcd_clock #(
  parameter int unsigned TICK_DIV = 100000000
) (
  input  logic        CLK100MHZ,
  input  logic        CPU_RESETN,
  input  logic        set_en,
  input  logic [23:0] set_time,
  output logic [23:0] out,
  output logic        sec_tick
);

  localparam int unsigned     DW       = $clog2(TICK_DIV);
  localparam logic [DW-1:0]   DIV_LAST = DW'(TICK_DIV - 1);

  logic [DW-1:0] div_cnt;
  logic [23:0]   next_time;
  logic          set_valid;

  logic [3:0] ht, hu, mt, mu, st, su;
  logic [3:0] n_ht, n_hu, n_mt, n_mu, n_st, n_su;

  assign {ht, hu, mt, mu, st, su} = out;

  // Loads are accepted only if every digit is in range and hours stay below 24.
  always_comb begin
    set_valid = (set_time[19:16] <= 4'd9) && (set_time[11:8] <= 4'd9) &&
                (set_time[3:0]   <= 4'd9) && (set_time[15:12] <= 4'd5) &&
                (set_time[7:4]   <= 4'd5) &&
                ((set_time[23:20] < 4'd2) ||
                 ((set_time[23:20] == 4'd2) && (set_time[19:16] <= 4'd3)));
  end

  // Ripple the carry digit by digit; every digit is still registered on one edge.
  always_comb begin
    n_ht = ht;
    n_hu = hu;
    n_mt = mt;
    n_mu = mu;
    n_st = st;
    n_su = su;
    if (su != 4'd9) begin
      n_su = su + 4'd1;
    end else begin
      n_su = 4'd0;
      if (st != 4'd5) begin
        n_st = st + 4'd1;
      end else begin
        n_st = 4'd0;
        if (mu != 4'd9) begin
          n_mu = mu + 4'd1;
        end else begin
          n_mu = 4'd0;
          if (mt != 4'd5) begin
            n_mt = mt + 4'd1;
          end else begin
            n_mt = 4'd0;
            if ((ht == 4'd2) && (hu == 4'd3)) begin
              n_ht = 4'd0;
              n_hu = 4'd0;
            end else if (hu != 4'd9) begin
              n_hu = hu + 4'd1;
            end else begin
              n_hu = 4'd0;
              n_ht = ht + 4'd1;
            end
          end
        end
      end
    end
    next_time = {n_ht, n_hu, n_mt, n_mu, n_st, n_su};
  end

  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      out      <= '0;
      div_cnt  <= '0;
      sec_tick <= 1'b0;
    end else if (set_en && set_valid) begin
      out      <= set_time;
      div_cnt  <= '0;
      sec_tick <= 1'b0;
    end else if (div_cnt == DIV_LAST) begin
      out      <= next_time;
      div_cnt  <= '0;
      sec_tick <= 1'b1;
    end else begin
      div_cnt  <= div_cnt + 1'b1;
      sec_tick <= 1'b0;
    end
  end

endmodule

// File: tb/tb_bcd_clock.sv
// Randomized and directed bench for bcd_clock against a seconds-of-day reference model.
module tb_bcd_clock;

  localparam int TDIV = 4;

  logic        clk;
  logic        rst_n;
  logic        set_en;
  logic [23:0] set_time;
  logic [23:0] out;
  logic        sec_tick;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state: seconds since midnight plus prescaler phase.
  int m_secs  = 0;
  int m_phase = 0;
  bit m_tick  = 0;

  bcd_clock #(.TICK_DIV(TDIV)) dut (
    .CLK100MHZ (clk),
    .CPU_RESETN(rst_n),
    .set_en    (set_en),
    .set_time  (set_time),
    .out       (out),
    .sec_tick  (sec_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200us;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [23:0] got, input logic [23:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [23:0] to_bcd(input int s);
    int h, m, sc;
    logic [23:0] r;
    h  = s / 3600;
    m  = (s / 60) % 60;
    sc = s % 60;
    r[23:20] = 4'(h / 10);
    r[19:16] = 4'(h % 10);
    r[15:12] = 4'(m / 10);
    r[11:8]  = 4'(m % 10);
    r[7:4]   = 4'(sc / 10);
    r[3:0]   = 4'(sc % 10);
    return r;
  endfunction

  function automatic bit legal(input logic [23:0] t);
    int d[6];
    for (int i = 0; i < 6; i++) d[i] = int'(t[4*i +: 4]);
    for (int i = 0; i < 6; i++) if (d[i] > 9) return 0;
    if (d[1] > 5 || d[3] > 5) return 0;
    if (d[5] * 10 + d[4] > 23) return 0;
    return 1;
  endfunction

  function automatic int from_bcd(input logic [23:0] t);
    return (int'(t[23:20]) * 10 + int'(t[19:16])) * 3600 +
           (int'(t[15:12]) * 10 + int'(t[11:8])) * 60 +
           int'(t[7:4]) * 10 + int'(t[3:0]);
  endfunction

  task automatic model_reset();
    m_secs  = 0;
    m_phase = 0;
    m_tick  = 0;
  endtask

  task automatic model_edge();
    if (!rst_n) begin
      model_reset();
    end else if (set_en && legal(set_time)) begin
      m_secs  = from_bcd(set_time);
      m_phase = 0;
      m_tick  = 0;
    end else if (m_phase == TDIV - 1) begin
      m_phase = 0;
      m_secs  = (m_secs + 1) % 86400;
      m_tick  = 1;
    end else begin
      m_phase++;
      m_tick = 0;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    check("model_out", out, to_bcd(m_secs));
    check("model_tick", 24'(sec_tick), 24'(m_tick));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic load(input logic [23:0] t);
    set_en   = 1'b1;
    set_time = t;
    cycle();
    set_en   = 1'b0;
  endtask

  logic [23:0] prev;

  initial begin
    rst_n    = 1'b0;
    set_en   = 1'b0;
    set_time = '0;

    // Reset and first increments
    run(3);
    check("rst_out", out, 24'h000000);
    check("rst_tick", 24'(sec_tick), 24'h0);
    rst_n = 1'b1;
    run(3);
    check("pre_first_tick", out, 24'h000000);
    cycle();
    check("first_tick_out", out, 24'h000001);
    check("first_tick_pulse", 24'(sec_tick), 24'h1);
    run(4);
    check("second_tick_out", out, 24'h000002);

    // Seconds and minute carry
    load(24'h000958);
    run(TDIV);
    check("carry_959", out, 24'h000959);
    run(TDIV);
    check("carry_1000", out, 24'h001000);

    // Day wrap
    load(24'h235959);
    run(TDIV);
    check("wrap_out", out, 24'h000000);
    check("wrap_tick", 24'(sec_tick), 24'h1);
    run(TDIV);
    check("wrap_next", out, 24'h000001);

    // Hour digit carries
    load(24'h095959);
    run(TDIV);
    check("hour_09_10", out, 24'h100000);
    load(24'h195959);
    run(TDIV);
    check("hour_19_20", out, 24'h200000);

    // Invalid loads are ignored; model keeps counting
    load(24'h246000);
    load(24'h126000);
    load(24'h1A0000);
    run(2);
    check("invalid_ignored", out, to_bcd(m_secs));
    load(24'h123456);
    check("valid_load", out, 24'h123456);
    run(TDIV - 1);
    check("load_restart_hold", out, 24'h123456);
    cycle();
    check("load_restart_tick", out, 24'h123457);

    // set_en held high freezes the time
    set_en   = 1'b1;
    set_time = 24'h080000;
    for (int i = 0; i < 10; i++) begin
      cycle();
      check("held_frozen", out, 24'h080000);
    end
    set_en = 1'b0;
    run(TDIV);
    check("held_release", out, 24'h080001);

    // Async reset mid-count
    load(24'h000000);
    run(3 * TDIV);
    check("pre_async", out, 24'h000003);
    run(2);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_out", out, 24'h000000);
    check("async_tick", 24'(sec_tick), 24'h0);
    model_reset();
    cycle();
    rst_n = 1'b1;
    prev = out;
    for (int i = 0; i < 30; i++) begin
      cycle();
      check("run_legal", 24'(legal(out)), 24'h1);
      check("run_monotonic", 24'(from_bcd(out) >= from_bcd(prev)), 24'h1);
      prev = out;
    end

    // Randomized loads (valid and arbitrary) against the model
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 19) == 0) begin
        set_en   = 1'b1;
        set_time = ($urandom_range(0, 1) == 0) ? 24'($urandom)
                                               : to_bcd(int'($urandom_range(0, 86399)));
        if ($urandom_range(0, 3) == 0) set_time = to_bcd(86399 - int'($urandom_range(0, 2)));
      end else begin
        set_en = 1'b0;
      end
      cycle();
    end
    set_en = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
